// File: rtl/spi_pkg.sv
// Shared SPI command definitions: opcode encodings, FSM states and default widths.
// The slave side imports the same opcode constants.
package spi_pkg;

  localparam int CMD_W_DEF  = 10;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_END     = 3'd5
  } state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// Generic shift register: parallel load, MSB-first shift with serial input at the LSB.
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         shift_i,
  input  logic         sin_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q;

  // Pure datapath: contents are only meaningful after a load or a full shift-in.
  always_ff @(posedge clk) begin
    if (load_i) begin
      data_q <= data_i;
    end else if (shift_i) begin
      data_q <= {data_q[W-2:0], sin_i};
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/spi_master_cmd.sv
// SPI command master: serialises 10-bit commands inside an SS_n frame and, for
// read-data commands, collects the returned byte after a fixed turnaround.
module spi_master_cmd
  import spi_pkg::*;
#(
  parameter int CMD_W   = CMD_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RD_WAIT = 2
) (
  input  logic              clk,
  input  logic              a_rst_n,
  input  logic              cmd_valid,
  input  logic [CMD_W-1:0]  cmd_word,
  output logic              cmd_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                is_rd_q;
  logic                ss_n_q, mosi_q, cmd_ready_q, busy_q;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [CMD_W-1:0]    tx_data;
  logic [DATA_W-1:0]   rx_data;
  logic                accept;
  logic                unused_tx_lsbs;

  assign accept = cmd_valid && cmd_ready_q;

  spi_shift_reg #(.W(CMD_W)) u_tx (
    .clk     (clk),
    .load_i  (accept),
    .data_i  (cmd_word),
    .shift_i (state_d == ST_SHIFT),
    .sin_i   (1'b0),
    .data_o  (tx_data)
  );

  spi_shift_reg #(.W(DATA_W)) u_rx (
    .clk     (clk),
    .load_i  (1'b0),
    .data_i  ({DATA_W{1'b0}}),
    .shift_i (state_q == ST_CAPTURE),
    .sin_i   (MISO),
    .data_o  (rx_data)
  );

  // Only the MSB of the TX register drives the line.
  assign unused_tx_lsbs = ^tx_data[CMD_W-2:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_START;
      end
      ST_START: begin
        state_d = ST_SHIFT;
        cnt_d   = 4'd0;
      end
      ST_SHIFT: begin
        if (cnt_q == 4'(CMD_W - 1)) begin
          cnt_d   = 4'd0;
          state_d = is_rd_q ? ST_WAIT : ST_END;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'(RD_WAIT - 1)) begin
          cnt_d   = 4'd0;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_CAPTURE: begin
        if (cnt_q == 4'(DATA_W - 1)) begin
          state_d     = ST_END;
          rsp_valid_d = 1'b1;
          rsp_data_d  = {rx_data[DATA_W-2:0], MISO};
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!a_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      is_rd_q     <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if (accept) is_rd_q <= (cmd_word[CMD_W-1 -: 2] == OP_RD_DATA);
      ss_n_q      <= (state_d == ST_IDLE) || (state_d == ST_END);
      mosi_q      <= (state_d == ST_SHIFT) && tx_data[CMD_W-1];
      cmd_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master_cmd.sv
// Bench for spi_master_cmd with a behavioural SPI slave + RAM model driving MISO.
module tb_spi_master_cmd;

  localparam int RD_WAIT = 2;

  logic       clk = 1'b0;
  logic       a_rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [9:0] cmd_word = '0;
  logic       MISO = 1'b0;
  logic       cmd_ready, rsp_valid, busy, SS_n, MOSI;
  logic [7:0] rsp_data;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] last_rsp = 8'h00;

  always #5 clk = ~clk;

  spi_master_cmd #(.CMD_W(10), .DATA_W(8), .RD_WAIT(RD_WAIT)) dut (
    .clk       (clk),
    .a_rst_n   (a_rst_n),
    .cmd_valid (cmd_valid),
    .cmd_word  (cmd_word),
    .cmd_ready (cmd_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  // Slave + RAM model in frame-position terms: position 0 is the first SS_n-low
  // cycle, positions 1..10 carry the command MSB first, the byte returns
  // RD_WAIT idle positions later.
  logic [9:0] frm_word[$];
  int         frm_len[$];
  int         frm_gap[$];
  int         m_pos = 0;
  int         m_p = 0;
  int         m_gap = 100;
  logic [9:0] m_sh = '0;
  logic       m_rd = 1'b0;
  logic [7:0] m_tx = '0;
  logic [7:0] m_addr = '0;
  logic [7:0] m_ram [256];

  always @(negedge clk) begin
    m_p = m_pos;
    if (SS_n === 1'b0) begin
      if (m_p == 0) frm_gap.push_back(m_gap);
      if (m_p >= 1 && m_p <= 10) m_sh = {m_sh[8:0], MOSI};
      if (m_p == 10) begin
        case (m_sh[9:8])
          2'b00, 2'b10: m_addr = m_sh[7:0];
          2'b01:        m_ram[m_addr] = m_sh[7:0];
          default: begin m_rd = 1'b1; m_tx = m_ram[m_addr]; end
        endcase
      end
      m_pos = m_p + 1;
    end else begin
      if (m_p > 0) begin
        frm_word.push_back(m_sh);
        frm_len.push_back(m_p);
        m_gap = 0;
      end
      m_pos = 0;
      m_rd  = 1'b0;
      m_gap++;
    end
    if (m_rd && m_p >= 11 + RD_WAIT && m_p < 19 + RD_WAIT) MISO = m_tx[7 - (m_p - 11 - RD_WAIT)];
    else MISO = 1'($urandom);
  end

  logic [7:0] rsp_q[$];
  int         rsp_wide = 0;
  logic       prev_rv = 1'b0;

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      rsp_q.push_back(rsp_data);
      if (prev_rv) rsp_wide++;
    end
    prev_rv = (rsp_valid === 1'b1);
  end

  task automatic clear_obs();
    frm_word.delete();
    frm_len.delete();
    frm_gap.delete();
    rsp_q.delete();
  endtask

  task automatic send(input logic [9:0] w, input bit hold);
    int n = 0;
    cmd_word  = w;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_timeout word=%h cmd_ready=%b required=1", w, cmd_ready);
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_word  = 10'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(cmd_ready === 1'b1 && busy === 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_timeout cmd_ready=%b busy=%b required=1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({SS_n, MOSI, cmd_ready, busy, rsp_valid, rsp_data} !== {5'b10000, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state got=%b required=%b",
               {SS_n, MOSI, cmd_ready, busy, rsp_valid, rsp_data}, {5'b10000, 8'h00});
    end
    @(posedge clk); #1 a_rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge got=%b required=0", cmd_ready); end
    @(negedge clk);
    n_chk++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_release got=%b required=1", cmd_ready); end

    // Abort a read-data frame during its capture window.
    m_ram[m_addr] = 8'h5C;
    send(10'h300, 1'b0);
    repeat (15) @(negedge clk);
    a_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({SS_n, MOSI, busy, rsp_valid, cmd_ready} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_midframe got=%b required=10000", {SS_n, MOSI, busy, rsp_valid, cmd_ready});
    end
    a_rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_abort got=%b required=1", cmd_ready); end
    repeat (25) @(negedge clk);
    n_chk++;
    if (rsp_q.size() != 0 || rsp_data !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_no_rsp pulses=%0d data=%h required=0/00", rsp_q.size(), rsp_data);
    end
    n_chk++;
    if (frm_len.size() != 1 || frm_len[0] >= 19 + RD_WAIT) begin
      n_fail++;
      $display("FAIL abort_frame_len frames=%0d required=1 truncated", frm_len.size());
    end
    clear_obs();
  endtask

  task automatic test_write_frames();
    logic [9:0]  w;
    logic [12:0] got, exp;
    for (int i = 0; i < 8; i++) begin
      w = (i == 0) ? 10'h0A5 : {2'($urandom_range(0, 2)), 8'($urandom)};
      clear_obs();
      send(w, 1'b0);
      for (int k = 1; k <= 13; k++) begin
        @(negedge clk);
        exp = {(k >= 12), ((k >= 2 && k <= 11) ? w[11 - k] : 1'b0), (k <= 12), (k == 13), 1'b0, last_rsp};
        got = {SS_n, MOSI, busy, cmd_ready, rsp_valid, rsp_data};
        n_chk++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL wr_cycle word=%h k=%0d got=%b required=%b", w, k, got, exp);
        end
      end
      n_chk++;
      if (frm_word.size() != 1 || frm_word[0] !== w || frm_len[0] != 11) begin
        n_fail++;
        $display("FAIL wr_frame frames=%0d word=%h len=%0d required=1/%h/11", frm_word.size(),
                 (frm_word.size() > 0) ? frm_word[0] : 10'h0, (frm_len.size() > 0) ? frm_len[0] : 0, w);
      end
    end
  endtask

  task automatic test_read_frames();
    logic [9:0]  w;
    logic [7:0]  d;
    logic [12:0] got, exp;
    int          len;
    len = 19 + RD_WAIT;
    for (int i = 0; i < 6; i++) begin
      w = (i == 0) ? 10'h300 : {2'b11, 8'($urandom)};
      d = (i == 0) ? 8'hC3 : 8'($urandom);
      m_ram[m_addr] = d;
      clear_obs();
      send(w, 1'b0);
      for (int k = 1; k <= len + 2; k++) begin
        @(negedge clk);
        exp = {(k > len), ((k >= 2 && k <= 11) ? w[11 - k] : 1'b0), (k <= len + 1), (k == len + 2),
               (k == len + 1), ((k > len) ? d : last_rsp)};
        got = {SS_n, MOSI, busy, cmd_ready, rsp_valid, rsp_data};
        n_chk++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL rd_cycle word=%h k=%0d got=%b required=%b", w, k, got, exp);
        end
      end
      last_rsp = d;
      n_chk++;
      if (frm_len.size() != 1 || frm_len[0] != len || rsp_q.size() != 1) begin
        n_fail++;
        $display("FAIL rd_frame frames=%0d pulses=%0d required=1/1 len=%0d", frm_len.size(), rsp_q.size(), len);
      end
    end
  endtask

  task automatic test_back_to_back();
    wait_idle();
    clear_obs();
    send(10'h15A, 1'b1);
    send(10'h011, 1'b0);
    wait_idle();
    n_chk++;
    if (frm_word.size() != 2 || frm_word[0] !== 10'h15A || frm_word[1] !== 10'h011) begin
      n_fail++;
      $display("FAIL b2b_words frames=%0d required=2 (15a,011)", frm_word.size());
    end
    n_chk++;
    if (frm_gap.size() != 2 || frm_gap[1] != 2) begin
      n_fail++;
      $display("FAIL b2b_gap got=%0d required=2", (frm_gap.size() > 1) ? frm_gap[1] : -1);
    end
    n_chk++;
    if (frm_len.size() != 2 || frm_len[0] != 11 || frm_len[1] != 11 || rsp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_len frames=%0d pulses=%0d required=2 frames of 11, 0 pulses", frm_len.size(), rsp_q.size());
    end
  endtask

  task automatic test_busy_block();
    logic [9:0] w;
    w = {2'b01, 8'($urandom)};
    wait_idle();
    clear_obs();
    send(w, 1'b1);
    repeat (5) @(negedge clk);
    send(10'h3FF, 1'b0);
    wait_idle();
    n_chk++;
    if (frm_word.size() != 2 || frm_word[0] !== w || frm_word[1] !== 10'h3FF) begin
      n_fail++;
      $display("FAIL busy_words frames=%0d first=%h required=2/%h then 3ff", frm_word.size(),
               (frm_word.size() > 0) ? frm_word[0] : 10'h0, w);
    end
    n_chk++;
    if (frm_gap.size() != 2 || frm_gap[1] != 2) begin
      n_fail++;
      $display("FAIL busy_gap got=%0d required=2", (frm_gap.size() > 1) ? frm_gap[1] : -1);
    end
    n_chk++;
    if (rsp_q.size() != 1 || rsp_q[0] !== w[7:0]) begin
      n_fail++;
      $display("FAIL busy_rsp pulses=%0d data=%h required=1/%h", rsp_q.size(),
               (rsp_q.size() > 0) ? rsp_q[0] : 8'h0, w[7:0]);
    end
    last_rsp = w[7:0];
  endtask

  task automatic test_integration();
    wait_idle();
    m_ram[8'h10] = 8'h00;
    clear_obs();
    send(10'h010, 1'b0);
    send(10'h1A7, 1'b0);
    send(10'h210, 1'b0);
    send(10'h300, 1'b0);
    wait_idle();
    n_chk++;
    if (rsp_q.size() != 1 || rsp_q[0] !== 8'hA7 || rsp_data !== 8'hA7) begin
      n_fail++;
      $display("FAIL integ_rsp pulses=%0d data=%h required=1/a7", rsp_q.size(), rsp_data);
    end
    n_chk++;
    if (frm_word.size() != 4) begin
      n_fail++;
      $display("FAIL integ_frames got=%0d required=4", frm_word.size());
    end
    n_chk++;
    if (rsp_wide != 0) begin
      n_fail++;
      $display("FAIL rsp_pulse_width wide=%0d required=0", rsp_wide);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_ram[i] = 8'h00;
    test_reset();
    test_write_frames();
    test_read_frames();
    test_back_to_back();
    test_busy_block();
    test_integration();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_master_cmd.md
Name: spi_master_cmd

Overview:
- Command-side SPI master that sits directly upstream of the SPI slave/RAM subsystem and drives its MOSI/SS_n, capturing MISO.
- Accepts 10-bit command words from a host over a valid/ready handshake and serialises each one MSB first as one SS_n-framed transaction.
- For read-data commands (word[9:8]=2'b11) it also collects the 8-bit byte the slave returns and presents it as a one-cycle response.
- Shares clk with the slave; no separate SCLK.

Parameters:
- CMD_W, 10, command word width (2-bit opcode + 8-bit payload).
- DATA_W, 8, read-back data width.
- RD_WAIT, 2, idle cycles after the last command bit before the first MISO sample (RAM plus slave turnaround; legal 1..7).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- a_rst_n  in  1  reset; synchronous and active-low.
- cmd_valid  in  1  host presents cmd_word.
- cmd_word  in  CMD_W  [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload.
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
- rsp_valid  out  1  one-cycle pulse; rsp_data valid.
- rsp_data  out  DATA_W  byte captured from MISO; holds until next rsp_valid.
- busy  out  1  high from acceptance until the return to IDLE.
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.

Behaviour:
- All outputs are registered. On a clock edge with a_rst_n=0: SS_n=1, MOSI=0, cmd_ready=0, busy=0, rsp_valid=0, rsp_data=0, state=IDLE. cmd_ready rises on the first edge after reset deasserts.
- FSM states: IDLE, START, SHIFT, WAIT, CAPTURE, END. A 4-bit bit counter and a CMD_W shift register are used.
- IDLE: cmd_ready=1, SS_n=1. On acceptance at edge A, latch cmd_word and go to START. cmd_ready=0 and busy=1 from A.
- START (cycle A+1): SS_n=0, MOSI=0. Always go to SHIFT.
- SHIFT (cycles A+2..A+11): MOSI=word[9-k] on the k-th cycle; SS_n stays 0.
  - After bit 0: if opcode=11, go to WAIT; otherwise go to END.
- WAIT: RD_WAIT cycles with SS_n=0 and MOSI=0. Then go to CAPTURE.
- CAPTURE: 8 cycles sampling MISO MSB first into the data shift register.
  - On the 8th sample edge: rsp_data is loaded, rsp_valid=1 for exactly one cycle, and the state goes to END.
- END: SS_n=1 and MOSI=0 for exactly one cycle, then IDLE. The minimum SS_n-high gap between frames is 2 cycles (END + IDLE).
- Non-read frame: SS_n low for exactly 11 cycles. Read-data frame: SS_n low for 11+RD_WAIT+8 cycles.
- cmd_valid while busy: ignored. The host must hold it; no queueing.
- cmd_word changing after acceptance: has no effect (latched).
- Reset asserted mid-frame: frame aborted on that edge, SS_n=1, no rsp_valid, partial data discarded.
- MISO is ignored outside CAPTURE.

Decomposition:
- Shared package spi_pkg holds:
  - opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11;
  - the FSM state enum;
  - CMD_W/DATA_W defaults.
- The slave reuses the same opcode constants.
- One natural sub-module: spi_shift_reg (parallel load, serial out MSB first, serial in), instantiated once for TX and once for RX.
- The FSM and counter stay in the top.

Test Plan:
- Reset: a_rst_n=0 for 3 cycles mid-frame → SS_n=1, MOSI=0, busy=0, rsp_valid=0. cmd_ready=1 one cycle after release.
- Write-address 10'h0A5: SS_n low 11 cycles; MOSI sequence over SHIFT is 0,0,1,0,1,0,0,1,0,1; no rsp_valid; cmd_ready high at A+13.
- Read-data 10'h300 (RD_WAIT=2) with model driving MISO=8'hC3 starting 2 cycles after the last command bit → rsp_valid single pulse, rsp_data=8'hC3, SS_n low 21 cycles.
- Back-to-back: cmd_valid held high with 01_5A then 00_11 → second frame's SS_n falls exactly 2 high cycles after the first rises; no command dropped or duplicated.
- Busy blocking: cmd_word changed to 10'h3FF mid-frame with cmd_valid=1 → current MOSI stream unchanged; new command accepted only on the next IDLE.
- Integration: connect to slave+RAM; write addr 0x10, write data 0xA7, read addr 0x10, read data → rsp_data=8'hA7.
